exe_lsu_issue: RTL
==================

Name: exe_lsu_issue

Overview:
Parametrised load/store issue unit for the EXE stage of the pipelined CPU. It checks alignment, builds size/wstrb/wdata for the SRAM-like data bus (req/addr_ok/data_ok), and supports up to OUTSTANDING in-flight requests through an in-order tracking FIFO. On data_ok it returns sign- or zero-extended load data to MEM/WB. Requests that were in flight when a pipeline flush occurred are cancelled, and their responses are dropped.

Parameters:
DATA_W, 32, data bus width; legal values are 32 and 64. STRB_W = DATA_W/8.
ADDR_W, 32, address width.
OUTSTANDING, 2, maximum number of accepted but unanswered requests; range 1..8.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  EXE holds a valid memory operation
in_ready  output  1  operation consumed this cycle
in_load  input  1  1 = load, 0 = store
in_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when DATA_W=64)
in_unsigned  input  1  zero-extend the load result
in_addr  input  ADDR_W  effective address
in_wdata  input  DATA_W  store source register value
in_rd  input  5  load destination register
flush  input  1  exception/ertn flush from MEM/WB
excp_ale  output  1  alignment exception for the current operation
data_sram_req  output  1  bus request
data_sram_wr  output  1  1 = write
data_sram_size  output  2  equals in_size
data_sram_wstrb  output  STRB_W  byte enables; zero for loads
data_sram_addr  output  ADDR_W  equals in_addr
data_sram_wdata  output  DATA_W  lane-replicated store data
data_sram_addr_ok  input  1  address-phase handshake
data_sram_data_ok  input  1  response handshake; returned for both loads and stores
data_sram_rdata  input  DATA_W  read data
resp_valid  output  1  registered one-cycle pulse: a non-cancelled response
resp_is_load  output  1  the response belongs to a load
resp_rd  output  5  destination register of the response
resp_data  output  DATA_W  extended load data; 0 for stores
idle  output  1  no request in flight (count == 0)

Behaviour:
- Alignment check:
  - nbytes = 1 << in_size.
  - ale = in_valid & |(in_addr & (nbytes-1)).
  - in_size = 3 with DATA_W = 32 also raises ale.
  - excp_ale = ale (combinational).
- Bus request:
  - data_sram_req = in_valid & ~ale & ~flush & (count < OUTSTANDING).
  - There is no same-cycle bypass when the FIFO is full: a pop in the same cycle does not free a slot for a push.
  - data_sram_wr = data_sram_req & ~in_load.
  - Address, size, wstrb and wdata must stay stable while req is high and addr_ok is low. This is the upstream's responsibility; the unit adds no holding register.
- Consumption: in_ready = (data_sram_req & data_sram_addr_ok) | (ale & ~flush). An ale operation is consumed without any bus activity.
- Store formatting:
  - off = in_addr[log2(STRB_W)-1:0].
  - wstrb = ((1 << nbytes) - 1) << off.
  - wdata = low nbytes bytes of in_wdata replicated across every lane.
- Tracking FIFO:
  - Depth OUTSTANDING, circular with separate read and write pointers.
  - Entry = {load, size, unsigned, off, rd, cancel}.
  - Push on req & addr_ok; pop on data_ok when count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo OUTSTANDING.
- Flush:
  - Every entry present at the clock edge has cancel set to 1.
  - No push can occur in the flush cycle, because req is gated off.
  - A pop in the same cycle is still processed, and its response is suppressed.
  - Cancelled entries pop on data_ok with resp_valid = 0.
- Response path (registered, latency 1):
  - data_ok with a non-cancelled head at edge t gives resp_valid = 1 during cycle t+1.
  - Load data: shift rdata right by off*8, keep nbytes bytes, then sign-extend (unsigned = 0) or zero-extend to DATA_W.
- Spurious data_ok while count == 0: ignored. No pop, no response, state unchanged.
- Reset:
  - count, both pointers, every cancel bit, resp_valid, resp_is_load, resp_rd and resp_data are 0; idle = 1.
  - Requests in flight at reset are forgotten, and later data_ok pulses are ignored as spurious.
- Outputs reset to 0: data_sram_req, in_ready and excp_ale, since in_valid is 0 during reset.

Test Plan:
1. DATA_W=32: load word at 0x100, addr_ok the same cycle, data_ok 2 cycles later with rdata 0x8000_00F0 -> one-cycle req, in_ready=1, resp_valid one cycle after data_ok, resp_data 0x8000_00F0, idle returns to 1.
2. Load half, signed, at addr 0x102 with rdata 0xF234_5678 -> resp_data 0xFFFF_F234. Same with unsigned=1 -> 0x0000_F234. Load half at 0x101 -> excp_ale=1, req=0, in_ready=1.
3. Store byte at 0x203 with in_wdata 0x1234_56AB -> wr=1, wstrb=4'b1000, wdata 0xABAB_ABAB; data_ok -> resp_valid=1, resp_is_load=0.
4. OUTSTANDING=2: three back-to-back loads with addr_ok always high and data_ok held off -> third req stays low until the first data_ok; responses return in order with the correct resp_rd.
5. Two loads in flight, then flush -> no req in the flush cycle; the two data_ok pulses produce no resp_valid. A load issued after the flush responds normally.
6. DATA_W=64: load dword at 0x...08 -> wstrb 0, size 3, full 64-bit resp_data. Store half at offset 6 -> wstrb 8'b1100_0000.

Source files
------------

// File: rtl/exe_lsu_issue.sv
// EXE-stage load/store issue unit: alignment check, bus request formatting and an
// in-order tracking FIFO that returns extended load data and drops flushed responses.
module exe_lsu_issue #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_load,
    input  logic [1:0]            in_size,
    input  logic                  in_unsigned,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [4:0]            in_rd,
    input  logic                  flush,
    output logic                  excp_ale,
    output logic                  data_sram_req,
    output logic                  data_sram_wr,
    output logic [1:0]            data_sram_size,
    output logic [DATA_W/8-1:0]   data_sram_wstrb,
    output logic [ADDR_W-1:0]     data_sram_addr,
    output logic [DATA_W-1:0]     data_sram_wdata,
    input  logic                  data_sram_addr_ok,
    input  logic                  data_sram_data_ok,
    input  logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  resp_valid,
    output logic                  resp_is_load,
    output logic [4:0]            resp_rd,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  idle
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
    localparam logic             NO_DWORD = (DATA_W == 32);

    // Shift the addressed bytes down, then sign- or zero-extend to the bus width.
    function automatic logic [DATA_W-1:0] extend_load(
        input logic [DATA_W-1:0] raw,
        input logic [1:0]        size,
        input logic              uns
    );
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic [DATA_W-1:0]  r;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        r = raw;
        case (size)
            2'd0: if (uns) r = DATA_W'(raw[7:0]);  else r = DATA_W'(b);
            2'd1: if (uns) r = DATA_W'(raw[15:0]); else r = DATA_W'(h);
            2'd2: if (uns) r = DATA_W'(raw[31:0]); else r = DATA_W'(w);
            default: r = raw;
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;

    logic              ent_load   [OUTSTANDING];
    logic [1:0]        ent_size   [OUTSTANDING];
    logic              ent_uns    [OUTSTANDING];
    logic [OFF_W-1:0]  ent_off    [OUTSTANDING];
    logic [4:0]        ent_rd     [OUTSTANDING];
    logic              ent_cancel [OUTSTANDING];

    logic [2:0]        size_mask;
    logic [7:0]        strb_base;
    logic              ale;
    logic              full;
    logic              push;
    logic              pop;
    logic              resp_take;
    logic [OFF_W-1:0]  off;
    logic [STRB_W-1:0] store_strb;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] head_shifted;

    always_comb begin
        size_mask = 3'd0;
        strb_base = 8'h01;
        case (in_size)
            2'd0: begin size_mask = 3'd0; strb_base = 8'h01; end
            2'd1: begin size_mask = 3'd1; strb_base = 8'h03; end
            2'd2: begin size_mask = 3'd3; strb_base = 8'h0f; end
            default: begin size_mask = 3'd7; strb_base = 8'hff; end
        endcase
    end

    assign ale  = in_valid & ((|(in_addr[2:0] & size_mask)) | (NO_DWORD & (in_size == 2'd3)));
    assign off  = in_addr[OFF_W-1:0];
    assign full = (count >= CNT_MAX);

    assign excp_ale      = ale;
    assign data_sram_req = in_valid & ~ale & ~flush & ~full;
    assign data_sram_wr  = data_sram_req & ~in_load;
    assign in_ready      = (data_sram_req & data_sram_addr_ok) | (ale & ~flush);

    assign push = data_sram_req & data_sram_addr_ok;
    assign pop  = data_sram_data_ok & (count != '0);
    assign idle = (count == '0);

    assign store_strb      = STRB_W'(strb_base) << off;
    assign data_sram_wstrb = in_load ? '0 : store_strb;
    assign data_sram_size  = in_size;
    assign data_sram_addr  = in_addr;
    assign data_sram_wdata = wdata_rep;

    // Each lane repeats the low nbytes of the source, so byte i takes source byte i mod nbytes.
    always_comb begin
        wdata_rep = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wdata_rep[i*8 +: 8] = in_wdata[(i & int'(size_mask))*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
            for (int i = 0; i < OUTSTANDING; i++) ent_cancel[i] <= 1'b0;
        end else begin
            if (flush) begin
                for (int i = 0; i < OUTSTANDING; i++) ent_cancel[i] <= 1'b1;
            end
            if (push) begin
                ent_cancel[wptr] <= 1'b0;
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry payload carries no reset; only the cancel bits and pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_load[wptr] <= in_load;
            ent_size[wptr] <= in_size;
            ent_uns[wptr]  <= in_unsigned;
            ent_off[wptr]  <= off;
            ent_rd[wptr]   <= in_rd;
        end
    end

    assign head_shifted = data_sram_rdata >> {ent_off[rptr], 3'b000};
    // A pop coinciding with a flush belongs to a killed request even though its cancel bit is still clear.
    assign resp_take    = pop & ~ent_cancel[rptr] & ~flush;

    // Response stage: one-cycle registered pulse after data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid   <= 1'b0;
            resp_is_load <= 1'b0;
            resp_rd      <= '0;
            resp_data    <= '0;
        end else begin
            resp_valid <= resp_take;
            if (resp_take) begin
                resp_is_load <= ent_load[rptr];
                resp_rd      <= ent_rd[rptr];
                resp_data    <= ent_load[rptr]
                                ? extend_load(head_shifted, ent_size[rptr], ent_uns[rptr])
                                : '0;
            end
        end
    end

endmodule
